// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous
// instruction memory (slave). The address is a word address.
interface instr_fetch_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-3:0] imem_addr_o;
   logic [31:0]       imem_data_i;

   modport master (
      output imem_addr_o,
      input  imem_data_i
   );

   modport slave (
      input  imem_addr_o,
      output imem_data_i
   );
endinterface : instr_fetch_if

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction memory
// and presents an aligned {instruction, byte address} pair to the IF/ID register.
module instr_fetch #(
   parameter int                ADDR_W      = 14,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                BOOT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              halt_i,
   instr_fetch_if.master     imem,
   output logic [31:0]       Instr_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              valid_o,
   output logic              misalign_o,
   output logic [31:0]       fetch_cnt_o
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t            r_state,     w_state_next;
   logic [ADDR_W-1:0] r_pc,        w_pc_next;
   logic [3:0]        r_boot_cnt,  w_boot_cnt_next;
   logic              r_first_run, w_first_run_next;
   logic              r_misalign,  w_misalign_next;
   logic [31:0]       r_fetch_cnt, w_fetch_cnt_next;

   logic              w_valid;
   logic              w_accept;
   logic [ADDR_W-1:0] w_jump_tgt;
   logic              w_jump_misalign;

   assign w_jump_tgt      = {jump_addr_i[ADDR_W-1:2], 2'b00};
   assign w_jump_misalign = (jump_addr_i[1:0] != 2'b00);

   // The first RUN cycle only waits for mem[pc] to return, so it is never a real fetch.
   assign w_valid  = (r_state == RUN) && !r_first_run;
   assign w_accept = w_valid && !stall_i && !jump_i && !halt_i;

   always_comb begin
      // NOTE: every next-state signal gets a default before the case so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_boot_cnt_next  = r_boot_cnt;
      w_first_run_next = 1'b0;
      w_misalign_next  = r_misalign;

      unique case (r_state)
         BOOT: begin
            w_boot_cnt_next = r_boot_cnt + 4'd1;
            if (r_boot_cnt == BOOT_LAST) begin
               w_state_next     = RUN;
               w_first_run_next = 1'b1;
            end
         end

         RUN: begin
            if (halt_i) begin
               w_state_next = HALT;
            end else if (jump_i) begin
               // The aligned target is loaded even when the request was misaligned.
               w_pc_next = w_jump_tgt;
               if (w_jump_misalign) begin
                  w_misalign_next = 1'b1;
                  w_state_next    = HALT;
               end
            end else if (!stall_i && !r_first_run) begin
               w_pc_next = r_pc + ADDR_W'(4);
            end
         end

         HALT: begin
            w_state_next = HALT;
         end

         default: begin
            w_state_next = HALT;
         end
      endcase

      w_fetch_cnt_next = r_fetch_cnt + 32'(w_accept);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= BOOT;
         r_pc        <= RESET_PC;
         r_boot_cnt  <= 4'd0;
         r_first_run <= 1'b0;
         r_misalign  <= 1'b0;
         r_fetch_cnt <= 32'd0;
      end else begin
         r_state     <= w_state_next;
         r_pc        <= w_pc_next;
         r_boot_cnt  <= w_boot_cnt_next;
         r_first_run <= w_first_run_next;
         r_misalign  <= w_misalign_next;
         r_fetch_cnt <= w_fetch_cnt_next;
      end
   end

   // Presenting pc_next lets the registered memory return mem[pc] as pc becomes visible.
   assign imem.imem_addr_o = w_pc_next[ADDR_W-1:2];

   assign addr_o      = r_pc;
   assign Instr_o     = w_valid ? imem.imem_data_i : 32'h0;
   assign valid_o     = w_valid;
   assign misalign_o  = r_misalign;
   assign fetch_cnt_o = r_fetch_cnt;

endmodule : instr_fetch

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and feeds it `Instr_o` / `addr_o`.
- Owns the program counter and drives the synchronous instruction memory.
- Handles stall-hold, jump redirect, halt and boot wait.
- Aligns returning memory data with the PC it belongs to, so the IF/ID register captures a consistent {instruction, address} pair.

Parameters:
- ADDR_W, 14, byte-address width of the PC; must match the IF/ID address width.
- RESET_PC, 14'h0000, PC loaded on reset; must be word-aligned.
- BOOT_CYCLES, 2, cycles spent in BOOT after reset release before fetching; range 1..15.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-unit hold; PC and outputs freeze.
- jump_i  in  1  redirect request from the branch/jump resolver; same signal that flushes the IF/ID register.
- jump_addr_i  in  ADDR_W  redirect target, byte address.
- halt_i  in  1  stop fetching; level, sampled each cycle.
- imem_addr_o  out  ADDR_W-2  word address to the instruction memory.
- imem_data_i  in  32  memory read data; registered inside the memory, valid the cycle after the address is presented.
- Instr_o  out  32  fetched instruction.
- addr_o  out  ADDR_W  byte address of `Instr_o`.
- valid_o  out  1  `Instr_o` / `addr_o` are a real fetch.
- misalign_o  out  1  sticky: a jump target had bits [1:0] != 0.
- fetch_cnt_o  out  32  count of accepted fetches.

Behaviour:
- State register values:
  - BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - Reset (async, rst_n=0) forces state=BOOT, pc_q=RESET_PC, boot_cnt=0, misalign_o=0, fetch_cnt_o=0.
- Memory addressing:
  - `imem_addr_o` is combinational: pc_next[ADDR_W-1:2].
  - The memory therefore returns mem[pc_q] in the cycle after pc_q is loaded, which is the same cycle pc_q is visible.
- Outputs:
  - `addr_o` = pc_q.
  - `Instr_o` = imem_data_i when valid_o=1, else 32'h0.
  - `valid_o` = (state==RUN) && !first_run_cycle.
  - During reset all outputs are 0, except `imem_addr_o`, which is RESET_PC[ADDR_W-1:2].
- BOOT state:
  - pc_next = pc_q; boot_cnt increments each cycle.
  - When boot_cnt == BOOT_CYCLES-1: state -> RUN, and first_run_cycle is set for one cycle, during which valid_o=0 while the memory produces mem[RESET_PC].
  - The first valid fetch appears exactly BOOT_CYCLES+1 cycles after rst_n rises.
  - stall_i and jump_i are ignored in BOOT.
- RUN state, pc_next priority (highest first):
  1. halt_i=1: pc_next=pc_q, state -> HALT.
  2. jump_i=1: pc_next = {jump_addr_i[ADDR_W-1:2], 2'b00}. If jump_addr_i[1:0] != 0, set misalign_o and state -> HALT; the PC is still loaded with the aligned target.
  3. stall_i=1: pc_next=pc_q. The same address is re-read, so Instr_o and addr_o are stable across the stall.
  4. Otherwise: pc_next = pc_q + 4, modulo 2^ADDR_W. 0x3FFC wraps to 0x0000 with no flag.
- Jump has priority over stall. The instruction on the outputs in the jump cycle is the fall-through; the IF/ID register discards it because it sees the same jump_i.
- The target instruction appears on the outputs the cycle after jump_i.
- HALT state:
  - pc_q frozen; valid_o=0.
  - Leaves only via reset; jump_i and stall_i are ignored.
- fetch_cnt_o:
  - Increments on every cycle with valid_o=1 && !stall_i && !jump_i && !halt_i.
  - Wraps at 2^32.
- Reset asserted mid-operation:
  - Immediate async return to the reset values.
  - A pending jump is lost.
  - misalign_o clears.

Test Plan:
- Reset release, no stimulus, mem[i]=i word → valid_o rises 3 cycles after rst_n rises with addr_o=0x0000, Instr_o=mem[0]; then addr_o steps 0x0004, 0x0008, …; fetch_cnt_o=5 after 5 valid cycles.
- stall_i high 3 cycles while addr_o=0x0010 → addr_o and Instr_o hold 0x0010 / mem[4] all 3 cycles; 0x0014 appears the cycle after stall_i drops; fetch_cnt_o does not advance during the stall.
- jump_i with jump_addr_i=0x0100 while stall_i=1 → next cycle addr_o=0x0100, Instr_o=mem[64]; jump wins over stall.
- PC at 0x3FFC, free-running → next addr_o=0x0000, Instr_o=mem[0], misalign_o stays 0.
- jump_i with jump_addr_i=0x0102 → misalign_o=1, state HALT, valid_o=0 from the next cycle; a later jump_i has no effect; rst_n low clears misalign_o and restarts BOOT.
- halt_i and jump_i asserted together at addr_o=0x0020 → pc holds 0x0020, valid_o=0 thereafter, fetch_cnt_o frozen; rst_n pulse mid-HALT → addr_o=0x0000, outputs zero, normal boot.
